// File: rtl/lc3_fetch_unit.sv
// LC3 instruction fetch stage: PC ownership, imem request/ack handshake, IR latch.
// Optional LC3_FETCH_TIMEOUT_EN adds a WAIT-cycle bound that forces a NOP fetch and pulses fetch_err.
module lc3_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_updatePC,
  input  logic        enable_fetch,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  input  logic [15:0] imem_dout,
  input  logic        imem_ack,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] pc,
  output logic [15:0] npc,
  output logic [15:0] IR,
  output logic        complete_instr,
  output logic        fetch_err
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for enable_fetch
  // WAIT  | imem_rd high, waiting for imem_ack (or timeout)
  // DONE  | IR valid, complete_instr high for this cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("lc3_fetch_unit: TIMEOUT must be in 1..255");
  end

  logic [1:0] state;
  logic       squash;
  logic       timeout_hit;

  assign npc = pc + 16'd1;

  always_ff @(posedge clock) begin
    if (reset)
      pc <= RESET_PC;
    else if (enable_updatePC)
      pc <= br_taken ? taddr : npc;
  end

`ifdef LC3_FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;

  assign timeout_hit = (wait_cnt == TIMEOUT_TC) && !imem_ack;

  always_ff @(posedge clock) begin
    if (reset)
      wait_cnt <= 8'd0;
    else if (state == S_IDLE && enable_fetch)
      wait_cnt <= 8'd0;
    else if (state == S_WAIT && !imem_ack)
      wait_cnt <= wait_cnt + 8'd1;
  end

  // A squashed fetch that times out is simply dropped, so no error pulse.
  always_ff @(posedge clock) begin
    if (reset)
      fetch_err <= 1'b0;
    else
      fetch_err <= (state == S_WAIT) && !squash && timeout_hit;
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      IR             <= 16'h0000;
      imem_addr      <= 16'h0000;
      imem_rd        <= 1'b0;
      complete_instr <= 1'b0;
      squash         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          complete_instr <= 1'b0;
          if (enable_fetch) begin
            imem_addr <= pc;
            imem_rd   <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_rd <= 1'b0;
            squash  <= 1'b0;
            if (!squash) begin
              IR             <= imem_dout;
              complete_instr <= 1'b1;
              state          <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (timeout_hit) begin
            imem_rd <= 1'b0;
            squash  <= 1'b0;
            if (!squash) begin
              IR             <= 16'h0000;
              complete_instr <= 1'b1;
              state          <= S_DONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (enable_updatePC && br_taken) begin
            // Data for the old path is still in flight; drop it when it lands.
            squash <= 1'b1;
          end
        end
        S_DONE: begin
          complete_instr <= 1'b0;
          state          <= S_IDLE;
        end
        default: begin
          complete_instr <= 1'b0;
          imem_rd        <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: PC update vector table plus hand-written fetch sequences.
module tb_lc3_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_updatePC;
  logic        enable_fetch;
  logic        br_taken;
  logic [15:0] taddr;
  logic [15:0] imem_dout;
  logic        imem_ack;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] pc;
  logic [15:0] npc;
  logic [15:0] IR;
  logic        complete_instr;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  lc3_fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enable_updatePC (enable_updatePC),
    .enable_fetch    (enable_fetch),
    .br_taken        (br_taken),
    .taddr           (taddr),
    .imem_dout       (imem_dout),
    .imem_ack        (imem_ack),
    .imem_addr       (imem_addr),
    .imem_rd         (imem_rd),
    .pc              (pc),
    .npc             (npc),
    .IR              (IR),
    .complete_instr  (complete_instr),
    .fetch_err       (fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        upd;
    logic        br;
    logic [15:0] taddr;
    logic [15:0] exp_pc;
    logic [15:0] exp_npc;
  } pc_vec_t;

  pc_vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    enable_updatePC = 1'b0;
    enable_fetch    = 1'b0;
    br_taken        = 1'b0;
    taddr           = 16'h0000;
    imem_ack        = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h3000, 16'h3001};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h3001, 16'h3002};
    vecs[2] = '{1'b1, 1'b1, 16'h3005, 16'h3005, 16'h3006};
    vecs[3] = '{1'b1, 1'b1, 16'h3100, 16'h3100, 16'h3101};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h3101, 16'h3102};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[7] = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0001};

    imem_dout = 16'h0000;
    do_reset();
    check("rst_pc", pc, 16'h3000);
    check("rst_ir", IR, 16'h0000);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_rd", {15'd0, imem_rd}, 16'd0);
    check("rst_complete", {15'd0, complete_instr}, 16'd0);
    check("rst_err", {15'd0, fetch_err}, 16'd0);

    // basic fetch, ack one cycle after request
    enable_fetch = 1'b1;
    tick();
    check("f1_rd", {15'd0, imem_rd}, 16'd1);
    check("f1_addr", imem_addr, 16'h3000);
    enable_fetch = 1'b0;
    imem_ack = 1'b1;
    imem_dout = 16'h1261;
    tick();
    imem_ack = 1'b0;
    check("f1_ir", IR, 16'h1261);
    check("f1_complete", {15'd0, complete_instr}, 16'd1);
    check("f1_rd_low", {15'd0, imem_rd}, 16'd0);
    tick();
    check("f1_complete_off", {15'd0, complete_instr}, 16'd0);

    // PC update table
    for (int i = 0; i < 8; i++) begin
      enable_updatePC = vecs[i].upd;
      br_taken        = vecs[i].br;
      taddr           = vecs[i].taddr;
      tick();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_npc", i), npc, vecs[i].exp_npc);
    end

    // delayed ack; non-branch PC update inside the wait
    do_reset();
    enable_fetch = 1'b1;
    tick();
    enable_fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable_updatePC = (i == 1);
      tick();
      enable_updatePC = 1'b0;
      check($sformatf("dly%0d_rd", i), {15'd0, imem_rd}, 16'd1);
      check($sformatf("dly%0d_addr", i), imem_addr, 16'h3000);
      check($sformatf("dly%0d_complete", i), {15'd0, complete_instr}, 16'd0);
    end
    check("dly_pc", pc, 16'h3001);
    imem_ack = 1'b1;
    imem_dout = 16'hABCD;
    tick();
    imem_ack = 1'b0;
    check("dly_ir", IR, 16'hABCD);
    check("dly_complete", {15'd0, complete_instr}, 16'd1);
    tick();

    // redirect during WAIT squashes the returning data
    enable_fetch = 1'b1;
    tick();
    enable_fetch = 1'b0;
    check("sq_addr", imem_addr, 16'h3001);
    enable_updatePC = 1'b1;
    br_taken = 1'b1;
    taddr = 16'h4000;
    tick();
    idle_inputs();
    check("sq_pc", pc, 16'h4000);
    imem_ack = 1'b1;
    imem_dout = 16'h5020;
    tick();
    imem_ack = 1'b0;
    check("sq_ir", IR, 16'hABCD);
    check("sq_complete", {15'd0, complete_instr}, 16'd0);
    check("sq_rd", {15'd0, imem_rd}, 16'd0);
    tick();
    check("sq_complete2", {15'd0, complete_instr}, 16'd0);
    enable_fetch = 1'b1;
    tick();
    enable_fetch = 1'b0;
    check("sq_next_addr", imem_addr, 16'h4000);
    check("sq_next_rd", {15'd0, imem_rd}, 16'd1);

    // ack coincides with redirect: data kept, pc redirected
    enable_updatePC = 1'b1;
    br_taken = 1'b1;
    taddr = 16'h5000;
    imem_ack = 1'b1;
    imem_dout = 16'h2222;
    tick();
    idle_inputs();
    check("co_ir", IR, 16'h2222);
    check("co_complete", {15'd0, complete_instr}, 16'd1);
    check("co_pc", pc, 16'h5000);
    tick();

    // ack outside WAIT is ignored
    imem_ack = 1'b1;
    imem_dout = 16'h3333;
    tick();
    imem_ack = 1'b0;
    check("ob_ir", IR, 16'h2222);
    check("ob_complete", {15'd0, complete_instr}, 16'd0);
    check("ob_rd", {15'd0, imem_rd}, 16'd0);

    // fetch and pc update on the same IDLE edge
    enable_fetch = 1'b1;
    enable_updatePC = 1'b1;
    tick();
    idle_inputs();
    check("se_addr", imem_addr, 16'h5000);
    check("se_pc", pc, 16'h5001);
    imem_ack = 1'b1;
    imem_dout = 16'h4444;
    tick();
    imem_ack = 1'b0;
    check("se_ir", IR, 16'h4444);
    tick();

    // no ack at all
    enable_fetch = 1'b1;
    tick();
    enable_fetch = 1'b0;
`ifdef LC3_FETCH_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      check($sformatf("to%0d_rd", i), {15'd0, imem_rd}, 16'd1);
      check($sformatf("to%0d_complete", i), {15'd0, complete_instr}, 16'd0);
    end
    tick();
    check("to_ir", IR, 16'h0000);
    check("to_complete", {15'd0, complete_instr}, 16'd1);
    check("to_err", {15'd0, fetch_err}, 16'd1);
    check("to_rd", {15'd0, imem_rd}, 16'd0);
    tick();
    check("to_complete_off", {15'd0, complete_instr}, 16'd0);
    check("to_err_off", {15'd0, fetch_err}, 16'd0);
    enable_fetch = 1'b1;
    tick();
    enable_fetch = 1'b0;
`else
    begin
      int err_seen = 0;
      int drop_seen = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (fetch_err !== 1'b0) err_seen++;
        if (imem_rd !== 1'b1 || complete_instr !== 1'b0) drop_seen++;
      end
      check("nto_err_cycles", 16'(err_seen), 16'd0);
      check("nto_rd_drop_cycles", 16'(drop_seen), 16'd0);
    end
`endif

    // reset mid-WAIT with a late ack
    tick();
    check("rw_rd_before", {15'd0, imem_rd}, 16'd1);
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_dout = 16'h7777;
    tick();
    reset = 1'b0;
    tick();
    imem_ack = 1'b0;
    check("rw_pc", pc, 16'h3000);
    check("rw_rd", {15'd0, imem_rd}, 16'd0);
    check("rw_ir", IR, 16'h0000);
    check("rw_complete", {15'd0, complete_instr}, 16'd0);
    tick();
    check("rw_complete2", {15'd0, complete_instr}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
